// File: rtl/vga_output_stage_if.sv
// VGA DAC-side bundle: active-low syncs, blanking and 4-bit colour channels.
// The stage drives it through master; monitors and DAC models observe it through slave.
interface vga_output_stage_if;
   logic       hSyncN;
   logic       vSyncN;
   logic       blankN;
   logic [3:0] vgaR;
   logic [3:0] vgaG;
   logic [3:0] vgaB;

   modport master (output hSyncN, vSyncN, blankN, vgaR, vgaG, vgaB);
   modport slave  (input  hSyncN, vSyncN, blankN, vgaR, vgaG, vgaB);
endinterface

// File: rtl/vga_output_stage.sv
// VGA timing generator and RGB332 -> 4:4:4 output stage with sync/colour alignment.
// Optional colour-bar source is enabled by defining VGA_TEST_PATTERN_EN.
module vga_output_stage #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int PIPE_DELAY = 1
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic [7:0]         RGBIn,
   input  logic               testMode,
   output logic [10:0]        pixelX,
   output logic [10:0]        pixelY,
   output logic               startOfFrame,
   vga_output_stage_if.master vga
);

   localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST   = 11'(HT - 1);
   localparam logic [10:0] V_LAST   = 11'(VT - 1);
   localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
   localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
   localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

   function automatic logic [3:0] expand3(input logic [2:0] c);
      return {c, c[2]};
   endfunction

   function automatic logic [3:0] expand2(input logic [1:0] c);
      return {c, c};
   endfunction

   logic [10:0] h_cnt;
   logic [10:0] v_cnt;
   logic        sof;
   logic        h_end;
   logic        v_end;

   assign h_end = (h_cnt == H_LAST);
   assign v_end = (v_cnt == V_LAST);

   // Stage p0: raster counters. startOfFrame is registered from the wrap
   // condition so the origin held during reset never produces a pulse.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         h_cnt <= '0;
         v_cnt <= '0;
         sof   <= 1'b0;
      end else begin
         sof <= h_end && v_end;
         if (h_end) begin
            h_cnt <= '0;
            v_cnt <= v_end ? 11'd0 : v_cnt + 11'd1;
         end else begin
            h_cnt <= h_cnt + 11'd1;
         end
      end
   end

   assign pixelX       = h_cnt;
   assign pixelY       = v_cnt;
   assign startOfFrame = sof;

   logic hs_raw;
   logic vs_raw;
   logic act_raw;

   assign hs_raw  = (h_cnt >= HS_START) && (h_cnt <= HS_END);
   assign vs_raw  = (v_cnt >= VS_START) && (v_cnt <= VS_END);
   assign act_raw = (h_cnt < H_VIS) && (v_cnt < V_VIS);

   logic [PIPE_DELAY-1:0] hs_p;
   logic [PIPE_DELAY-1:0] vs_p;
   logic [PIPE_DELAY-1:0] vld_p;

   // Stages p1..pN: timing flags wait for the pixel source to return RGBIn.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         hs_p  <= '0;
         vs_p  <= '0;
         vld_p <= '0;
      end else begin
         hs_p[0]  <= hs_raw;
         vs_p[0]  <= vs_raw;
         vld_p[0] <= act_raw;
         for (int i = 1; i < PIPE_DELAY; i++) begin
            hs_p[i]  <= hs_p[i-1];
            vs_p[i]  <= vs_p[i-1];
            vld_p[i] <= vld_p[i-1];
         end
      end
   end

   logic [7:0] colour_src;

`ifdef VGA_TEST_PATTERN_EN
   localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);

   function automatic logic [7:0] bar_colour(input logic [10:0] x);
      logic [2:0] k;
      k = 3'(x / BAR_W);
      return {{3{k[2]}}, {3{k[1]}}, {2{k[0]}}};
   endfunction

   logic [10:0] x_p [PIPE_DELAY];

   always_ff @(posedge clk) begin
      x_p[0] <= h_cnt;
      for (int i = 1; i < PIPE_DELAY; i++) begin
         x_p[i] <= x_p[i-1];
      end
   end

   always_comb begin
      colour_src = RGBIn;
      if (testMode) begin
         colour_src = bar_colour(x_p[PIPE_DELAY-1]);
      end
   end
`else
   logic unused_test_mode;

   assign unused_test_mode = testMode;
   assign colour_src       = RGBIn;
`endif

   // Output stage: syncs, blanking and colour leave together.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         vga.hSyncN <= 1'b1;
         vga.vSyncN <= 1'b1;
         vga.blankN <= 1'b0;
         vga.vgaR   <= 4'h0;
         vga.vgaG   <= 4'h0;
         vga.vgaB   <= 4'h0;
      end else begin
         vga.hSyncN <= ~hs_p[PIPE_DELAY-1];
         vga.vSyncN <= ~vs_p[PIPE_DELAY-1];
         vga.blankN <= vld_p[PIPE_DELAY-1];
         if (vld_p[PIPE_DELAY-1]) begin
            vga.vgaR <= expand3(colour_src[7:5]);
            vga.vgaG <= expand3(colour_src[4:2]);
            vga.vgaB <= expand2(colour_src[1:0]);
         end else begin
            vga.vgaR <= 4'h0;
            vga.vgaG <= 4'h0;
            vga.vgaB <= 4'h0;
         end
      end
   end

endmodule

// File: tb/tb_vga_output_stage.sv
// Directed bench for vga_output_stage: timing, alignment, blanking, reset and wrap.
// A short vertical raster keeps two whole frames inside a small cycle count.
module tb_vga_output_stage;

   localparam int V_ACT  = 6;
   localparam int V_FPB  = 2;
   localparam int V_SYN  = 2;
   localparam int V_BPB  = 3;
   localparam int HTOT   = 800;
   localparam int VTOT   = V_ACT + V_FPB + V_SYN + V_BPB;
   localparam int FRAME  = HTOT * VTOT;

   logic        clk;
   logic        resetN;
   logic [7:0]  RGBIn;
   logic        testMode;
   logic [10:0] pixelX;
   logic [10:0] pixelY;
   logic        startOfFrame;

   logic        use_x;
   logic [7:0]  rgb_const;
   logic [7:0]  x_q;

   int n_tests;
   int n_fail;

   vga_output_stage_if vga_bus ();

   vga_output_stage #(
      .V_ACTIVE (V_ACT),
      .V_FP     (V_FPB),
      .V_SYNC   (V_SYN),
      .V_BP     (V_BPB)
   ) dut (
      .clk          (clk),
      .resetN       (resetN),
      .RGBIn        (RGBIn),
      .testMode     (testMode),
      .pixelX       (pixelX),
      .pixelY       (pixelY),
      .startOfFrame (startOfFrame),
      .vga          (vga_bus)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   // Pixel source model: returns pixelX[7:0] one clock later.
   always @(posedge clk) x_q <= pixelX[7:0];
   assign RGBIn = use_x ? x_q : rgb_const;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic wait_xy(input int x, input int y, input string tag);
      int n;
      n = 0;
      while (!(pixelX == 11'(x) && pixelY == 11'(y)) && n < 3 * FRAME) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_reach"}, 32'(pixelX == 11'(x) && pixelY == 11'(y)), 32'd1);
   endtask

   function automatic logic [11:0] rgb();
      return {vga_bus.vgaR, vga_bus.vgaG, vga_bus.vgaB};
   endfunction

   initial begin
      int first_x, hs_fall, hs_fall_x, vs_fall, vs_first, vs_per;
      int sof_last, sof_first, sof_per, sof_cnt, vis, bad;
      int hs_per_min, hs_per_max, hs_low_min, hs_low_max, vs_low_min, vs_low_max;
      logic prev_hs, prev_vs;

      n_tests   = 0;
      n_fail    = 0;
      resetN    = 1'b0;
      testMode  = 1'b0;
      use_x     = 1'b0;
      rgb_const = 8'hE0;

      repeat (3) @(negedge clk);
      check("rst_x",     32'(pixelX), 32'd0);
      check("rst_y",     32'(pixelY), 32'd0);
      check("rst_sof",   32'(startOfFrame), 32'd0);
      check("rst_hs",    32'(vga_bus.hSyncN), 32'd1);
      check("rst_vs",    32'(vga_bus.vSyncN), 32'd1);
      check("rst_blank", 32'(vga_bus.blankN), 32'd0);
      check("rst_rgb",   32'(rgb()), 32'h000);

      resetN     = 1'b1;
      first_x    = -1;
      hs_fall    = -1;
      hs_fall_x  = -1;
      vs_fall    = -1;
      vs_first   = -1;
      vs_per     = -1;
      sof_last   = -1;
      sof_first  = -1;
      sof_per    = -1;
      sof_cnt    = 0;
      vis        = 0;
      bad        = 0;
      hs_per_min = 1 << 30;
      hs_per_max = 0;
      hs_low_min = 1 << 30;
      hs_low_max = 0;
      vs_low_min = 1 << 30;
      vs_low_max = 0;
      prev_hs    = 1'b1;
      prev_vs    = 1'b1;

      for (int n = 1; n <= 2 * FRAME + 1000; n++) begin
         @(negedge clk);
         if (n == 1) first_x = int'(pixelX);
         if (prev_hs && !vga_bus.hSyncN) begin
            if (hs_fall >= 0) begin
               if (n - hs_fall < hs_per_min) hs_per_min = n - hs_fall;
               if (n - hs_fall > hs_per_max) hs_per_max = n - hs_fall;
            end else begin
               hs_fall_x = int'(pixelX);
            end
            hs_fall = n;
         end
         if (!prev_hs && vga_bus.hSyncN && hs_fall >= 0) begin
            if (n - hs_fall < hs_low_min) hs_low_min = n - hs_fall;
            if (n - hs_fall > hs_low_max) hs_low_max = n - hs_fall;
         end
         if (prev_vs && !vga_bus.vSyncN) begin
            if (vs_fall >= 0) vs_per = n - vs_fall;
            else vs_first = n;
            vs_fall = n;
         end
         if (!prev_vs && vga_bus.vSyncN && vs_fall >= 0) begin
            if (n - vs_fall < vs_low_min) vs_low_min = n - vs_fall;
            if (n - vs_fall > vs_low_max) vs_low_max = n - vs_fall;
         end
         if (startOfFrame) begin
            sof_cnt++;
            if (sof_last >= 0) sof_per = n - sof_last;
            else sof_first = n;
            sof_last = n;
         end
         if (n <= 2 * FRAME && vga_bus.blankN) vis++;
         if (rgb() !== (vga_bus.blankN ? 12'hF00 : 12'h000)) bad++;
         prev_hs = vga_bus.hSyncN;
         prev_vs = vga_bus.vSyncN;
      end

      check("first_x",    32'(first_x), 32'd1);
      check("hs_per_min", 32'(hs_per_min), 32'd800);
      check("hs_per_max", 32'(hs_per_max), 32'd800);
      check("hs_low_min", 32'(hs_low_min), 32'd96);
      check("hs_low_max", 32'(hs_low_max), 32'd96);
      check("hs_fall_x",  32'(hs_fall_x), 32'd658);
      check("vs_first",   32'(vs_first), 32'(8 * HTOT + 2));
      check("vs_per",     32'(vs_per), 32'(FRAME));
      check("vs_low_min", 32'(vs_low_min), 32'd1600);
      check("vs_low_max", 32'(vs_low_max), 32'd1600);
      check("sof_first",  32'(sof_first), 32'(FRAME));
      check("sof_per",    32'(sof_per), 32'(FRAME));
      check("sof_cnt",    32'(sof_cnt), 32'd2);
      check("vis_count",  32'(vis), 32'(2 * 640 * V_ACT));
      check("red_blank",  32'(bad), 32'd0);

      // Pixel alignment: colour at pixelX==P belongs to X==P-2.
      use_x = 1'b1;
      wait_xy(0, 1, "align");
      for (int k = 1; k <= 643; k++) begin
         @(negedge clk);
         case (int'(pixelX))
            1:   check("align_blank_pre", 32'(vga_bus.blankN), 32'd0);
            2: begin
               check("align_blank_rise", 32'(vga_bus.blankN), 32'd1);
               check("align_x0", 32'(rgb()), 32'h000);
            end
            3:   check("align_x1",   32'(rgb()), 32'h005);
            47:  check("align_x45",  32'(rgb()), 32'h265);
            226: check("align_xe0",  32'(rgb()), 32'hF00);
            257: check("align_xff",  32'(rgb()), 32'hFFF);
            641: begin
               check("align_last_blank", 32'(vga_bus.blankN), 32'd1);
               check("align_x639", 32'(rgb()), 32'h6FF);
            end
            642: begin
               check("align_end_blank", 32'(vga_bus.blankN), 32'd0);
               check("align_end_rgb", 32'(rgb()), 32'h000);
            end
            default: ;
         endcase
      end

      testMode = 1'b1;
`ifdef VGA_TEST_PATTERN_EN
      use_x     = 1'b0;
      rgb_const = 8'h00;
      wait_xy(0, 2, "bars");
      for (int k = 1; k <= 643; k++) begin
         @(negedge clk);
         case (int'(pixelX))
            81:  check("bar_x79",  32'(rgb()), 32'h000);
            82:  check("bar_x80",  32'(rgb()), 32'h00F);
            161: check("bar_x159", 32'(rgb()), 32'h00F);
            562: check("bar_x560", 32'(rgb()), 32'hFFF);
            641: check("bar_x639", 32'(rgb()), 32'hFFF);
            default: ;
         endcase
      end
`else
      use_x     = 1'b0;
      rgb_const = 8'hE0;
      wait_xy(0, 2, "nobars");
      for (int k = 1; k <= 643; k++) begin
         @(negedge clk);
         if (pixelX == 11'd102) check("nobar_x100", 32'(rgb()), 32'hF00);
         if (pixelX == 11'd562) check("nobar_x560", 32'(rgb()), 32'hF00);
      end
`endif
      testMode  = 1'b0;
      rgb_const = 8'hE0;

      // Mid-frame reset takes effect without waiting for a clock edge.
      wait_xy(300, 5, "midrst");
      check("midrst_pre_blank", 32'(vga_bus.blankN), 32'd1);
      resetN = 1'b0;
      #1;
      check("midrst_x",     32'(pixelX), 32'd0);
      check("midrst_y",     32'(pixelY), 32'd0);
      check("midrst_blank", 32'(vga_bus.blankN), 32'd0);
      check("midrst_rgb",   32'(rgb()), 32'h000);
      check("midrst_hs",    32'(vga_bus.hSyncN), 32'd1);
      check("midrst_vs",    32'(vga_bus.vSyncN), 32'd1);
      repeat (3) @(negedge clk);
      check("midrst_hold_x", 32'(pixelX), 32'd0);
      check("midrst_hold_sof", 32'(startOfFrame), 32'd0);
      resetN = 1'b1;
      @(negedge clk);
      check("midrst_rel_x", 32'(pixelX), 32'd1);
      check("midrst_rel_y", 32'(pixelY), 32'd0);

      wait_xy(799, VTOT - 1, "wrap");
      check("wrap_pre_sof", 32'(startOfFrame), 32'd0);
      @(negedge clk);
      check("wrap_x",   32'(pixelX), 32'd0);
      check("wrap_y",   32'(pixelY), 32'd0);
      check("wrap_sof", 32'(startOfFrame), 32'd1);
      @(negedge clk);
      check("wrap_post_sof", 32'(startOfFrame), 32'd0);
      check("wrap_post_x",   32'(pixelX), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
